// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared key codes, front-end state encoding and transaction codes
package atm_pkg;

  localparam logic [3:0] KEY_ENTER    = 4'hA;
  localparam logic [3:0] KEY_CLEAR    = 4'hB;
  localparam logic [3:0] KEY_CANCEL   = 4'hC;
  localparam logic [3:0] KEY_BALANCE  = 4'hD;
  localparam logic [3:0] KEY_WITHDRAW = 4'hE;
  localparam logic [3:0] KEY_IGNORE   = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_PIN_ENTRY    = 3'd1,
    ST_MENU         = 3'd2,
    ST_AMOUNT_ENTRY = 3'd3,
    ST_WAIT_REMOVE  = 3'd4
  } fe_state_t;

  localparam logic [1:0] TXN_NONE     = 2'b00;
  localparam logic [1:0] TXN_BALANCE  = 2'b01;
  localparam logic [1:0] TXN_WITHDRAW = 2'b10;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_digit_accum.sv
// rtl/atm_digit_accum.sv - decimal digit to binary accumulator with count, clear and overflow reject
module atm_digit_accum
  import atm_pkg::*;
#(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic [3:0]  digit,
  output logic [15:0] value,
  output logic [2:0]  count,
  output logic        full
);

  assign full = (count == 3'(MAX_DIGITS));

  // acc*10 as shift-add; MAX_DIGITS<=4 keeps the result within 16 bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
      count <= '0;
    end else if (clear) begin
      value <= '0;
      count <= '0;
    end else if (push && !full) begin
      value <= (value << 3) + (value << 1) + 16'(digit);
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/atm_keypad_frontend.sv
// rtl/atm_keypad_frontend.sv - keypad/card front end; optional inactivity timeout via ATM_KEYPAD_TIMEOUT_EN
module atm_keypad_frontend
  import atm_pkg::*;
#(
  parameter int          PIN_DIGITS     = 4,
  parameter logic [23:0] STORED_PIN     = 24'h001234,
  parameter int          AMT_DIGITS     = 4,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        card_present,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        card_inserted,
  output logic        pin_entered,
  output logic        pin_correct,
  output logic        txn_valid,
  output logic [1:0]  transaction_choice,
  output logic [15:0] amount,
  output logic [2:0]  digit_count,
  output logic        key_error,
  output logic        locked,
  output logic        cancelled,
  output logic        timeout,
  output logic [2:0]  fe_state
);

  localparam int PW = 4 * PIN_DIGITS;
  localparam logic [PW-1:0] PIN_REF = STORED_PIN[PW-1:0];

  fe_state_t state_q, state_d;
  logic          card_q;
  logic [PW-1:0] pin_buf_q, pin_buf_d;
  logic [2:0]    pin_cnt_q, pin_cnt_d;
  logic [1:0]    attempts_q, attempts_d, attempts_nxt;
  logic          locked_d;
  logic [1:0]    choice_d;
  logic [15:0]   amount_d;
  logic          ci_d, pe_d, pc_d, tv_d, ke_d, ca_d, to_d;
  logic          acc_clear, acc_push, acc_full;
  logic [15:0]   acc_value;
  logic [2:0]    acc_count;
  logic          pin_full, pin_match, tmo_hit;

  atm_digit_accum #(.MAX_DIGITS(AMT_DIGITS)) u_amount (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .push  (acc_push),
    .digit (key_code),
    .value (acc_value),
    .count (acc_count),
    .full  (acc_full)
  );

  assign pin_full     = (pin_cnt_q == 3'(PIN_DIGITS));
  assign pin_match    = (pin_buf_q == PIN_REF);
  assign attempts_nxt = attempts_q + 2'd1;
  // Each count is zeroed whenever its state is left, so at most one is non-zero
  assign digit_count  = pin_cnt_q | acc_count;
  assign fe_state     = state_q;

`ifdef ATM_KEYPAD_TIMEOUT_EN
  logic [31:0] idle_cnt;
  logic        timed_state;
  assign timed_state = (state_q == ST_PIN_ENTRY) || (state_q == ST_MENU) ||
                       (state_q == ST_AMOUNT_ENTRY);
  assign tmo_hit = timed_state && (idle_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             idle_cnt <= '0;
    else if (key_valid || state_d != state_q || !timed_state) idle_cnt <= '0;
    else                                                   idle_cnt <= idle_cnt + 32'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pin_buf_d  = pin_buf_q;
    pin_cnt_d  = pin_cnt_q;
    attempts_d = attempts_q;
    locked_d   = locked;
    choice_d   = transaction_choice;
    amount_d   = amount;
    {ci_d, pe_d, pc_d, tv_d, ke_d, ca_d, to_d} = '0;
    acc_clear  = 1'b0;
    acc_push   = 1'b0;

    if (state_q != ST_IDLE && !card_present) begin
      state_d    = ST_IDLE;
      pin_buf_d  = '0;
      pin_cnt_d  = '0;
      attempts_d = '0;
      locked_d   = 1'b0;
      choice_d   = TXN_NONE;
      amount_d   = '0;
      acc_clear  = 1'b1;
    end else if (tmo_hit) begin
      state_d   = ST_WAIT_REMOVE;
      to_d      = 1'b1;
      pin_buf_d = '0;
      pin_cnt_d = '0;
      acc_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (card_present && !card_q) begin
          state_d    = ST_PIN_ENTRY;
          ci_d       = 1'b1;
          pin_buf_d  = '0;
          pin_cnt_d  = '0;
          attempts_d = '0;
          locked_d   = 1'b0;
          choice_d   = TXN_NONE;
          amount_d   = '0;
          acc_clear  = 1'b1;
        end
        ST_PIN_ENTRY: if (key_valid) begin
          if (is_digit(key_code)) begin
            if (pin_full) ke_d = 1'b1;
            else begin
              pin_buf_d = PW'({pin_buf_q, key_code});
              pin_cnt_d = pin_cnt_q + 3'd1;
            end
          end else begin
            case (key_code)
              KEY_ENTER: if (!pin_full) ke_d = 1'b1;
              else begin
                pe_d      = 1'b1;
                pc_d      = pin_match;
                pin_buf_d = '0;
                pin_cnt_d = '0;
                if (pin_match) state_d = ST_MENU;
                else begin
                  attempts_d = attempts_nxt;
                  if (attempts_nxt == 2'(MAX_ATTEMPTS)) begin
                    locked_d = 1'b1;
                    state_d  = ST_WAIT_REMOVE;
                  end
                end
              end
              KEY_CLEAR: begin
                pin_buf_d = '0;
                pin_cnt_d = '0;
              end
              KEY_CANCEL: begin
                ca_d      = 1'b1;
                state_d   = ST_WAIT_REMOVE;
                pin_buf_d = '0;
                pin_cnt_d = '0;
              end
              KEY_BALANCE, KEY_WITHDRAW: ke_d = 1'b1;
              default: ;
            endcase
          end
        end
        ST_MENU: if (key_valid) begin
          case (key_code)
            KEY_BALANCE: begin
              tv_d     = 1'b1;
              choice_d = TXN_BALANCE;
              amount_d = '0;
              state_d  = ST_WAIT_REMOVE;
            end
            KEY_WITHDRAW: begin
              state_d   = ST_AMOUNT_ENTRY;
              acc_clear = 1'b1;
            end
            KEY_CANCEL: begin
              ca_d    = 1'b1;
              state_d = ST_WAIT_REMOVE;
            end
            KEY_IGNORE: ;
            default: ke_d = 1'b1;
          endcase
        end
        ST_AMOUNT_ENTRY: if (key_valid) begin
          if (is_digit(key_code)) begin
            if (acc_full) ke_d = 1'b1;
            else          acc_push = 1'b1;
          end else begin
            case (key_code)
              KEY_ENTER: if (acc_value == 16'd0) ke_d = 1'b1;
              else begin
                tv_d      = 1'b1;
                choice_d  = TXN_WITHDRAW;
                amount_d  = acc_value;
                state_d   = ST_WAIT_REMOVE;
                acc_clear = 1'b1;
              end
              KEY_CLEAR: acc_clear = 1'b1;
              KEY_CANCEL: begin
                ca_d      = 1'b1;
                state_d   = ST_WAIT_REMOVE;
                acc_clear = 1'b1;
              end
              KEY_BALANCE, KEY_WITHDRAW: ke_d = 1'b1;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      // Preset high so a card left in across reset is not seen as a new insertion
      card_q             <= 1'b1;
      pin_buf_q          <= '0;
      pin_cnt_q          <= '0;
      attempts_q         <= '0;
      locked             <= 1'b0;
      transaction_choice <= TXN_NONE;
      amount             <= '0;
      card_inserted      <= 1'b0;
      pin_entered        <= 1'b0;
      pin_correct        <= 1'b0;
      txn_valid          <= 1'b0;
      key_error          <= 1'b0;
      cancelled          <= 1'b0;
      timeout            <= 1'b0;
    end else begin
      state_q            <= state_d;
      card_q             <= card_present;
      pin_buf_q          <= pin_buf_d;
      pin_cnt_q          <= pin_cnt_d;
      attempts_q         <= attempts_d;
      locked             <= locked_d;
      transaction_choice <= choice_d;
      amount             <= amount_d;
      card_inserted      <= ci_d;
      pin_entered        <= pe_d;
      pin_correct        <= pc_d;
      txn_valid          <= tv_d;
      key_error          <= ke_d;
      cancelled          <= ca_d;
      timeout            <= to_d;
    end
  end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// tb/tb_atm_keypad_frontend.sv - scoreboard bench for atm_keypad_frontend
module tb_atm_keypad_frontend;
  import atm_pkg::*;

  logic        clk = 1'b0;
  logic        reset, card_present, key_valid;
  logic [3:0]  key_code;
  logic        card_inserted, pin_entered, pin_correct, txn_valid;
  logic [1:0]  transaction_choice;
  logic [15:0] amount;
  logic [2:0]  digit_count, fe_state;
  logic        key_error, locked, cancelled, timeout;

  atm_keypad_frontend #(
    .PIN_DIGITS(4), .STORED_PIN(24'h001234), .AMT_DIGITS(4),
    .MAX_ATTEMPTS(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .card_present(card_present),
    .key_valid(key_valid), .key_code(key_code),
    .card_inserted(card_inserted), .pin_entered(pin_entered),
    .pin_correct(pin_correct), .txn_valid(txn_valid),
    .transaction_choice(transaction_choice), .amount(amount),
    .digit_count(digit_count), .key_error(key_error), .locked(locked),
    .cancelled(cancelled), .timeout(timeout), .fe_state(fe_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] obs;
  logic        pulse_any;
  assign obs = {4'b0, card_inserted, pin_entered, pin_correct, txn_valid,
                transaction_choice, amount, key_error, cancelled, timeout, fe_state};
  assign pulse_any = card_inserted | pin_entered | txn_valid | key_error | cancelled | timeout;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] ev(input logic ci, input logic pe, input logic pc,
                                     input logic tv, input logic [1:0] ch,
                                     input logic [15:0] amt, input logic ke,
                                     input logic ca, input logic to, input logic [2:0] st);
    return {4'b0, ci, pe, pc, tv, ch, amt, ke, ca, to, st};
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset && pulse_any) begin
      if (exp_q.size() == 0) expect_eq("unexpected_event", obs, 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        expect_eq(e.tag, obs, e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    @(posedge clk);
    #1 key_valid = 1'b1;
    key_code = c;
    @(posedge clk);
    #1 key_valid = 1'b0;
    key_code = 4'h0;
  endtask

  task automatic card_in();
    push("card_inserted", ev(1, 0, 0, 0, TXN_NONE, 0, 0, 0, 0, ST_PIN_ENTRY));
    @(posedge clk);
    #1 card_present = 1'b1;
    tick(2);
  endtask

  task automatic card_out();
    @(posedge clk);
    #1 card_present = 1'b0;
    tick(2);
  endtask

  task automatic err(input string tag, input logic [2:0] st, input logic [3:0] c);
    push(tag, ev(0, 0, 0, 0, TXN_NONE, 0, 1, 0, 0, st));
    press(c);
  endtask

  task automatic pin_ok();
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    push("pin_ok", ev(0, 1, 1, 0, TXN_NONE, 0, 0, 0, 0, ST_MENU));
    press(KEY_ENTER);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; card_present = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    tick(3);
    expect_eq("reset_events", obs, 32'd0);
    expect_eq("reset_locked", locked, 0);
    @(negedge clk) reset = 1'b0;
    tick(1);
    expect_eq("post_reset_state", fe_state, ST_IDLE);
    expect_eq("post_reset_digits", digit_count, 0);

    // correct PIN, menu errors, balance
    card_in();
    expect_eq("pin_state", fe_state, ST_PIN_ENTRY);
    press(4'd1); press(4'd2); press(4'd3);
    expect_eq("pin_three_digits", digit_count, 3);
    press(4'd4);
    push("pin_ok", ev(0, 1, 1, 0, TXN_NONE, 0, 0, 0, 0, ST_MENU));
    press(KEY_ENTER);
    expect_eq("menu_state", fe_state, ST_MENU);
    expect_eq("menu_digits", digit_count, 0);
    err("menu_clear_err", ST_MENU, KEY_CLEAR);
    err("menu_digit_err", ST_MENU, 4'd5);
    press(KEY_IGNORE);
    push("balance", ev(0, 0, 0, 1, TXN_BALANCE, 0, 0, 0, 0, ST_WAIT_REMOVE));
    press(KEY_BALANCE);
    expect_eq("balance_choice", transaction_choice, TXN_BALANCE);
    press(4'd1);
    press(KEY_CANCEL);
    card_out();
    expect_eq("balance_removed_state", fe_state, ST_IDLE);
    expect_eq("balance_removed_choice", transaction_choice, TXN_NONE);

    // PIN entry errors, overflow and cancel from menu
    card_in();
    err("pin_short_enter", ST_PIN_ENTRY, KEY_ENTER);
    err("pin_balance_err", ST_PIN_ENTRY, KEY_BALANCE);
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    err("pin_fifth_digit", ST_PIN_ENTRY, 4'd5);
    expect_eq("pin_full_digits", digit_count, 4);
    push("pin_ok_after_overflow", ev(0, 1, 1, 0, TXN_NONE, 0, 0, 0, 0, ST_MENU));
    press(KEY_ENTER);
    push("menu_cancel", ev(0, 0, 0, 0, TXN_NONE, 0, 0, 1, 0, ST_WAIT_REMOVE));
    press(KEY_CANCEL);
    card_out();

    // three wrong PINs lock the card
    card_in();
    for (int i = 0; i < 3; i++) begin
      press(4'd1); press(4'd2); press(4'd3); press(4'd5);
      push("pin_wrong", ev(0, 1, 0, 0, TXN_NONE, 0, 0, 0, 0,
                           (i == 2) ? ST_WAIT_REMOVE : ST_PIN_ENTRY));
      press(KEY_ENTER);
      if (i == 1) expect_eq("not_locked_yet", locked, 0);
    end
    expect_eq("locked_level", locked, 1);
    expect_eq("locked_state", fe_state, ST_WAIT_REMOVE);
    press(4'd7);
    card_out();
    expect_eq("unlock_on_removal", locked, 0);
    expect_eq("idle_after_lock", fe_state, ST_IDLE);

    // withdrawal of 250 with a CLEAR first
    card_in();
    pin_ok();
    press(KEY_WITHDRAW);
    expect_eq("amount_state", fe_state, ST_AMOUNT_ENTRY);
    press(4'd7);
    press(KEY_CLEAR);
    expect_eq("amount_clear_digits", digit_count, 0);
    press(4'd0); press(4'd2); press(4'd5); press(4'd0);
    expect_eq("amount_four_digits", digit_count, 4);
    push("withdraw_250", ev(0, 0, 0, 1, TXN_WITHDRAW, 16'd250, 0, 0, 0, ST_WAIT_REMOVE));
    press(KEY_ENTER);
    tick(5);
    expect_eq("amount_held", amount, 250);
    expect_eq("choice_held", transaction_choice, TXN_WITHDRAW);
    card_out();
    expect_eq("amount_cleared", amount, 0);

    // zero-amount ENTER and digit overflow
    card_in();
    pin_ok();
    press(KEY_WITHDRAW);
    err("amount_zero_enter", ST_AMOUNT_ENTRY, KEY_ENTER);
    for (int i = 0; i < 4; i++) press(4'd9);
    err("amount_fifth_digit", ST_AMOUNT_ENTRY, 4'd9);
    push("withdraw_9999", ev(0, 0, 0, 1, TXN_WITHDRAW, 16'd9999, 0, 0, 0, ST_WAIT_REMOVE));
    press(KEY_ENTER);
    expect_eq("amount_9999", amount, 9999);
    card_out();

    // card removal with a simultaneous key strobe
    card_in();
    press(4'd1); press(4'd2);
    expect_eq("mid_pin_digits", digit_count, 2);
    @(posedge clk);
    #1 card_present = 1'b0;
    key_valid = 1'b1;
    key_code = 4'd3;
    @(posedge clk);
    #1 key_valid = 1'b0;
    expect_eq("removal_state", fe_state, ST_IDLE);
    expect_eq("removal_digits", digit_count, 0);
    tick(2);

    // async reset mid-entry with the card left in
    card_in();
    press(4'd1); press(4'd2);
    #3 reset = 1'b1;
    #1;
    expect_eq("async_reset_state", fe_state, ST_IDLE);
    expect_eq("async_reset_digits", digit_count, 0);
    tick(2);
    @(negedge clk) reset = 1'b0;
    tick(4);
    expect_eq("no_reinsert_state", fe_state, ST_IDLE);
    card_out();
    card_in();
    press(4'd8);
    expect_eq("fresh_buffer", digit_count, 1);
    card_out();

    // inactivity in MENU
    card_in();
    pin_ok();
`ifdef ATM_KEYPAD_TIMEOUT_EN
    tick(15);
    expect_eq("no_timeout_early", timeout, 0);
    push("timeout", ev(0, 0, 0, 0, TXN_NONE, 0, 0, 0, 1, ST_WAIT_REMOVE));
    tick(1);
    expect_eq("timeout_state", fe_state, ST_WAIT_REMOVE);
`else
    tick(20);
    expect_eq("no_timeout", timeout, 0);
    expect_eq("menu_waits", fe_state, ST_MENU);
`endif
    card_out();

    tick(3);
    expect_eq("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
